// File: rtl/universal_reg.sv
// universal_reg
// General-purpose WIDTH-bit storage element for datapath exercises.
// Supports hold, parallel load, shift left/right, rotate left/right and
// count up/down. Also provides true and complemented outputs, the last
// shifted-out bit, and a terminal-count flag.
// Reset is asynchronous and has the highest priority. Set is synchronous
// and overrides every mode operation. Mode operations occur only while en
// is high.

module universal_reg #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] SET_VALUE   = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] D,
   input  logic             sin,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_n,
   output logic             sout,
   output logic             tc
);

   // Operation encodings. They are given names so that the next-state and
   // tc logic read as intent instead of raw bit patterns.
   typedef enum logic [2:0] {
      MODE_HOLD   = 3'b000,
      MODE_LOAD   = 3'b001,
      MODE_SHL    = 3'b010,
      MODE_SHR    = 3'b011,
      MODE_ROL    = 3'b100,
      MODE_ROR    = 3'b101,
      MODE_CNT_UP = 3'b110,
      MODE_CNT_DN = 3'b111
   } mode_e;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   mode_e            modeSel;
   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;
   logic             sout_q;
   logic             sout_d;
   logic             tcFlag;

   assign modeSel = mode_e'(mode);

   // Next-state selection.
   // Set overrides everything. After set, en gates the mode operation.
   // Modes that do not move a bit out of the register leave sout alone.
   // Because of this, sout always reports the bit lost by the most recent
   // shift or rotate.
   always_comb begin
      value_d = value_q;
      sout_d  = sout_q;
      if (set) begin
         value_d = SET_VALUE;
         sout_d  = 1'b0;
      end else if (en) begin
         case (modeSel)
            MODE_HOLD: begin
               value_d = value_q;
            end
            MODE_LOAD: begin
               value_d = D;
            end
            MODE_SHL: begin
               value_d = {value_q[WIDTH-2:0], sin};
               sout_d  = value_q[WIDTH-1];
            end
            MODE_SHR: begin
               value_d = {sin, value_q[WIDTH-1:1]};
               sout_d  = value_q[0];
            end
            MODE_ROL: begin
               value_d = {value_q[WIDTH-2:0], value_q[WIDTH-1]};
               sout_d  = value_q[WIDTH-1];
            end
            MODE_ROR: begin
               value_d = {value_q[0], value_q[WIDTH-1:1]};
               sout_d  = value_q[0];
            end
            MODE_CNT_UP: begin
               value_d = value_q + ONE;
            end
            MODE_CNT_DN: begin
               value_d = value_q - ONE;
            end
            default: begin
               value_d = value_q;
            end
         endcase
      end
   end

   // State register.
   // Reset acts immediately and holds the register while asserted, so a
   // partially completed shift or count is discarded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= RESET_VALUE;
         sout_q  <= 1'b0;
      end else begin
         value_q <= value_d;
         sout_q  <= sout_d;
      end
   end

   // Terminal count.
   // The flag looks at the selected count direction even when en is low.
   // A counter can therefore see tc before it issues the wrapping step.
   // The flag is held low while reset is asserted.
   always_comb begin
      tcFlag = 1'b0;
      if (!reset) begin
         case (modeSel)
            MODE_CNT_UP: tcFlag = &value_q;
            MODE_CNT_DN: tcFlag = ~|value_q;
            default:     tcFlag = 1'b0;
         endcase
      end
   end

   assign Q    = value_q;
   assign Q_n  = ~value_q;
   assign sout = sout_q;
   assign tc   = tcFlag;

endmodule

// File: tb/tb_universal_reg.sv
// tb_universal_reg
// Scenario-based bench for universal_reg with WIDTH=8 and default values.
// Each scenario drives one cycle at a time. When a stimulus is driven, the
// expected result is pushed to a scoreboard queue. The entry is popped and
// compared once the DUT has produced its output.

module tb_universal_reg;

   typedef struct {
      string      name;
      logic [7:0] q;
      logic       so;
      logic       t;
   } exp_t;

   typedef struct {
      string      name;
      logic       setV;
      logic       enV;
      logic [2:0] modeV;
      logic [7:0] dV;
      logic       sinV;
      logic [7:0] q;
      logic       so;
      logic       t;
   } step_t;

   logic       clk;
   logic       reset;
   logic       set;
   logic       en;
   logic [2:0] mode;
   logic [7:0] D;
   logic       sin;
   logic [7:0] Q;
   logic [7:0] Q_n;
   logic       sout;
   logic       tc;

   exp_t sbQ[$];
   int   testsRun  = 0;
   int   failCount = 0;

   universal_reg #(.WIDTH(8)) dut (
      .clk  (clk),
      .reset(reset),
      .set  (set),
      .en   (en),
      .mode (mode),
      .D    (D),
      .sin  (sin),
      .Q    (Q),
      .Q_n  (Q_n),
      .sout (sout),
      .tc   (tc)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the bench always ends, even if it gets stuck.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not reach summary, failed=%0d", failCount);
      $fatal(1, "[TB] timeout");
   end

   function automatic step_t mk(string n, logic s, logic e, logic [2:0] m,
                                logic [7:0] d, logic si, logic [7:0] q,
                                logic so, logic t);
      step_t r;
      r.name = n; r.setV = s; r.enV = e; r.modeV = m; r.dV = d; r.sinV = si;
      r.q = q; r.so = so; r.t = t;
      return r;
   endfunction

   task automatic applyStimulus(input logic s, input logic e, input logic [2:0] m,
                                input logic [7:0] d, input logic si);
      set  = s;
      en   = e;
      mode = m;
      D    = d;
      sin  = si;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t  e;
      step_t steps[$];
      applyStimulus(1'b0, 1'b0, 3'b000, 8'h00, 1'b0);
      #2 reset = 1'b1;
      tick();
      sbQ.push_back('{"reset_initial", 8'h00, 1'b0, 1'b0});
      e = sbQ.pop_front();
      testsRun++;
      if ({Q, Q_n, sout, tc} !== {e.q, ~e.q, e.so, e.t}) begin
         failCount++;
         $display("[TB] FAIL %s: got Q=%h Q_n=%h sout=%b tc=%b, expected Q=%h Q_n=%h sout=%b tc=%b",
                  e.name, Q, Q_n, sout, tc, e.q, ~e.q, e.so, e.t);
      end
      reset = 1'b0;
      steps.push_back(mk("reset_load_AD", 1'b0, 1'b1, 3'b001, 8'hAD, 1'b0, 8'hAD, 1'b0, 1'b0));
      steps.push_back(mk("reset_shl_5A",  1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 8'h5A, 1'b1, 1'b0));
      foreach (steps[i]) begin
         applyStimulus(steps[i].setV, steps[i].enV, steps[i].modeV, steps[i].dV, steps[i].sinV);
         sbQ.push_back('{steps[i].name, steps[i].q, steps[i].so, steps[i].t});
         tick();
         e = sbQ.pop_front();
         testsRun++;
         if ({Q, Q_n, sout, tc} !== {e.q, ~e.q, e.so, e.t}) begin
            failCount++;
            $display("[TB] FAIL %s: got Q=%h Q_n=%h sout=%b tc=%b, expected Q=%h Q_n=%h sout=%b tc=%b",
                     e.name, Q, Q_n, sout, tc, e.q, ~e.q, e.so, e.t);
         end
      end
      // Assert reset mid-cycle with set and load pending. Then select
      // count-down at Q=0, which would raise tc if reset were not asserted.
      #2;
      applyStimulus(1'b1, 1'b1, 3'b001, 8'hFF, 1'b1);
      reset = 1'b1;
      sbQ.push_back('{"reset_async_immediate", 8'h00, 1'b0, 1'b0});
      #1;
      e = sbQ.pop_front();
      testsRun++;
      if ({Q, Q_n, sout, tc} !== {e.q, ~e.q, e.so, e.t}) begin
         failCount++;
         $display("[TB] FAIL %s: got Q=%h Q_n=%h sout=%b tc=%b, expected Q=%h Q_n=%h sout=%b tc=%b",
                  e.name, Q, Q_n, sout, tc, e.q, ~e.q, e.so, e.t);
      end
      mode = 3'b111;
      for (int k = 0; k < 2; k++) begin
         sbQ.push_back('{"reset_over_set_hold", 8'h00, 1'b0, 1'b0});
         tick();
         e = sbQ.pop_front();
         testsRun++;
         if ({Q, Q_n, sout, tc} !== {e.q, ~e.q, e.so, e.t}) begin
            failCount++;
            $display("[TB] FAIL %s: got Q=%h Q_n=%h sout=%b tc=%b, expected Q=%h Q_n=%h sout=%b tc=%b",
                     e.name, Q, Q_n, sout, tc, e.q, ~e.q, e.so, e.t);
         end
      end
   endtask

   task automatic test_priority();
      exp_t  e;
      step_t steps[$];
      reset = 1'b0;
      steps.push_back(mk("prio_set_over_load", 1'b1, 1'b1, 3'b001, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0));
      steps.push_back(mk("prio_en0_hold_1",    1'b0, 1'b0, 3'b001, 8'h33, 1'b0, 8'hFF, 1'b0, 1'b0));
      steps.push_back(mk("prio_en0_hold_2",    1'b0, 1'b0, 3'b001, 8'h33, 1'b0, 8'hFF, 1'b0, 1'b0));
      foreach (steps[i]) begin
         applyStimulus(steps[i].setV, steps[i].enV, steps[i].modeV, steps[i].dV, steps[i].sinV);
         sbQ.push_back('{steps[i].name, steps[i].q, steps[i].so, steps[i].t});
         tick();
         e = sbQ.pop_front();
         testsRun++;
         if ({Q, Q_n, sout, tc} !== {e.q, ~e.q, e.so, e.t}) begin
            failCount++;
            $display("[TB] FAIL %s: got Q=%h Q_n=%h sout=%b tc=%b, expected Q=%h Q_n=%h sout=%b tc=%b",
                     e.name, Q, Q_n, sout, tc, e.q, ~e.q, e.so, e.t);
         end
      end
   endtask

   task automatic test_shift();
      exp_t  e;
      step_t steps[$];
      steps.push_back(mk("shift_load_96", 1'b0, 1'b1, 3'b001, 8'h96, 1'b0, 8'h96, 1'b0, 1'b0));
      steps.push_back(mk("shift_shl",     1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 8'h2D, 1'b1, 1'b0));
      steps.push_back(mk("shift_shr",     1'b0, 1'b1, 3'b011, 8'hFF, 1'b0, 8'h16, 1'b1, 1'b0));
      steps.push_back(mk("shift_hold_md", 1'b0, 1'b1, 3'b000, 8'hFF, 1'b1, 8'h16, 1'b1, 1'b0));
      steps.push_back(mk("shift_en0",     1'b0, 1'b0, 3'b011, 8'hFF, 1'b1, 8'h16, 1'b1, 1'b0));
      foreach (steps[i]) begin
         applyStimulus(steps[i].setV, steps[i].enV, steps[i].modeV, steps[i].dV, steps[i].sinV);
         sbQ.push_back('{steps[i].name, steps[i].q, steps[i].so, steps[i].t});
         tick();
         e = sbQ.pop_front();
         testsRun++;
         if ({Q, Q_n, sout, tc} !== {e.q, ~e.q, e.so, e.t}) begin
            failCount++;
            $display("[TB] FAIL %s: got Q=%h Q_n=%h sout=%b tc=%b, expected Q=%h Q_n=%h sout=%b tc=%b",
                     e.name, Q, Q_n, sout, tc, e.q, ~e.q, e.so, e.t);
         end
      end
   endtask

   task automatic test_rotate();
      exp_t  e;
      step_t steps[$];
      steps.push_back(mk("rot_load_81", 1'b0, 1'b1, 3'b001, 8'h81, 1'b0, 8'h81, 1'b1, 1'b0));
      steps.push_back(mk("rot_rol",     1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0));
      steps.push_back(mk("rot_ror_1",   1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 8'h81, 1'b1, 1'b0));
      steps.push_back(mk("rot_ror_2",   1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 8'hC0, 1'b1, 1'b0));
      steps.push_back(mk("rot_ror_3",   1'b0, 1'b1, 3'b101, 8'h00, 1'b1, 8'h60, 1'b0, 1'b0));
      foreach (steps[i]) begin
         applyStimulus(steps[i].setV, steps[i].enV, steps[i].modeV, steps[i].dV, steps[i].sinV);
         sbQ.push_back('{steps[i].name, steps[i].q, steps[i].so, steps[i].t});
         tick();
         e = sbQ.pop_front();
         testsRun++;
         if ({Q, Q_n, sout, tc} !== {e.q, ~e.q, e.so, e.t}) begin
            failCount++;
            $display("[TB] FAIL %s: got Q=%h Q_n=%h sout=%b tc=%b, expected Q=%h Q_n=%h sout=%b tc=%b",
                     e.name, Q, Q_n, sout, tc, e.q, ~e.q, e.so, e.t);
         end
      end
   endtask

   task automatic test_counter_wrap();
      exp_t  e;
      step_t steps[$];
      steps.push_back(mk("cnt_load_FE",    1'b0, 1'b1, 3'b001, 8'hFE, 1'b0, 8'hFE, 1'b0, 1'b0));
      steps.push_back(mk("cnt_up_FE_tc0",  1'b0, 1'b0, 3'b110, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0));
      steps.push_back(mk("cnt_up_FF_tc1",  1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1));
      steps.push_back(mk("cnt_tc_en0",     1'b0, 1'b0, 3'b110, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1));
      steps.push_back(mk("cnt_up_wrap_00", 1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
      steps.push_back(mk("cnt_dn_wrap_FF", 1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0));
      foreach (steps[i]) begin
         applyStimulus(steps[i].setV, steps[i].enV, steps[i].modeV, steps[i].dV, steps[i].sinV);
         sbQ.push_back('{steps[i].name, steps[i].q, steps[i].so, steps[i].t});
         tick();
         e = sbQ.pop_front();
         testsRun++;
         if ({Q, Q_n, sout, tc} !== {e.q, ~e.q, e.so, e.t}) begin
            failCount++;
            $display("[TB] FAIL %s: got Q=%h Q_n=%h sout=%b tc=%b, expected Q=%h Q_n=%h sout=%b tc=%b",
                     e.name, Q, Q_n, sout, tc, e.q, ~e.q, e.so, e.t);
         end
      end
   endtask

   task automatic test_countdown_reset();
      exp_t  e;
      step_t steps[$];
      steps.push_back(mk("dn_load_02", 1'b0, 1'b1, 3'b001, 8'h02, 1'b0, 8'h02, 1'b0, 1'b0));
      steps.push_back(mk("dn_01",      1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0));
      steps.push_back(mk("dn_00_tc1",  1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1));
      steps.push_back(mk("up_01",      1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0));
      steps.push_back(mk("up_02",      1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0));
      foreach (steps[i]) begin
         applyStimulus(steps[i].setV, steps[i].enV, steps[i].modeV, steps[i].dV, steps[i].sinV);
         sbQ.push_back('{steps[i].name, steps[i].q, steps[i].so, steps[i].t});
         tick();
         e = sbQ.pop_front();
         testsRun++;
         if ({Q, Q_n, sout, tc} !== {e.q, ~e.q, e.so, e.t}) begin
            failCount++;
            $display("[TB] FAIL %s: got Q=%h Q_n=%h sout=%b tc=%b, expected Q=%h Q_n=%h sout=%b tc=%b",
                     e.name, Q, Q_n, sout, tc, e.q, ~e.q, e.so, e.t);
         end
      end
      // Pulse reset between edges while counting up. Counting restarts from 0.
      #2 reset = 1'b1;
      sbQ.push_back('{"up_midreset", 8'h00, 1'b0, 1'b0});
      #1;
      e = sbQ.pop_front();
      testsRun++;
      if ({Q, Q_n, sout, tc} !== {e.q, ~e.q, e.so, e.t}) begin
         failCount++;
         $display("[TB] FAIL %s: got Q=%h Q_n=%h sout=%b tc=%b, expected Q=%h Q_n=%h sout=%b tc=%b",
                  e.name, Q, Q_n, sout, tc, e.q, ~e.q, e.so, e.t);
      end
      #1 reset = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         sbQ.push_back('{"up_resume", 8'(k), 1'b0, 1'b0});
         tick();
         e = sbQ.pop_front();
         testsRun++;
         if ({Q, Q_n, sout, tc} !== {e.q, ~e.q, e.so, e.t}) begin
            failCount++;
            $display("[TB] FAIL %s: got Q=%h Q_n=%h sout=%b tc=%b, expected Q=%h Q_n=%h sout=%b tc=%b",
                     e.name, Q, Q_n, sout, tc, e.q, ~e.q, e.so, e.t);
         end
      end
   endtask

   // Random back-to-back operations checked against a behavioural model.
   task automatic test_back_to_back();
      exp_t       e;
      logic [7:0] mQ;
      logic       mSout;
      logic       s, en_r, si;
      logic [2:0] m;
      logic [7:0] d;
      mQ    = 8'h02;
      mSout = 1'b0;
      for (int k = 0; k < 60; k++) begin
         s    = ($urandom_range(0, 9) == 0);
         en_r = ($urandom_range(0, 4) != 0);
         m    = 3'($urandom_range(0, 7));
         d    = 8'($urandom);
         si   = 1'($urandom);
         applyStimulus(s, en_r, m, d, si);
         if (s) begin
            mQ = 8'hFF; mSout = 1'b0;
         end else if (en_r) begin
            if (m == 3'd1) mQ = d;
            else if (m == 3'd2) begin mSout = mQ[7]; mQ = (mQ << 1) | {7'd0, si}; end
            else if (m == 3'd3) begin mSout = mQ[0]; mQ = (mQ >> 1) | {si, 7'd0}; end
            else if (m == 3'd4) begin mSout = mQ[7]; mQ = (mQ << 1) | (mQ >> 7); end
            else if (m == 3'd5) begin mSout = mQ[0]; mQ = (mQ >> 1) | (mQ << 7); end
            else if (m == 3'd6) mQ = mQ + 8'd1;
            else if (m == 3'd7) mQ = mQ - 8'd1;
         end
         sbQ.push_back('{"b2b_random", mQ, mSout,
                         (m == 3'd6 && mQ == 8'hFF) || (m == 3'd7 && mQ == 8'h00)});
         tick();
         e = sbQ.pop_front();
         testsRun++;
         if ({Q, Q_n, sout, tc} !== {e.q, ~e.q, e.so, e.t}) begin
            failCount++;
            $display("[TB] FAIL %s[%0d]: got Q=%h Q_n=%h sout=%b tc=%b, expected Q=%h Q_n=%h sout=%b tc=%b",
                     e.name, k, Q, Q_n, sout, tc, e.q, ~e.q, e.so, e.t);
         end
      end
   endtask

   // Scenario sequence.
   initial begin
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 3'b000, 8'h00, 1'b0);
      test_reset();
      test_priority();
      test_shift();
      test_rotate();
      test_counter_wrap();
      test_countdown_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
